mem_arb: RTL

// - Shares the single RAM port between three requesters: loader (program image writes),

---
 rtl/mem_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// Arbitrates the single RAM port between loader writes, instruction fetch and data access,
// routing read data back by owner. Optional round-robin arbitration: define MEM_ARB_RR_EN.
module mem_arb #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [3:0]    d_wstrb,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic [3:0]    ram_wstrb,
  input  logic [DW-1:0] ram_rdata,
  output logic [31:0]   cnt_if_gnt,
  output logic [31:0]   cnt_d_gnt,
  output logic [31:0]   cnt_stall
);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  logic              d_wins;
  logic              rd_gnt;
  logic              rd_own;
  logic              stall_evt;
  logic              rsp_vld;
  logic              rsp_own;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_own_q;
  logic [31:0]       cnt_if_q;
  logic [31:0]       cnt_d_q;
  logic [31:0]       cnt_stall_q;

`ifdef MEM_ARB_RR_EN
  // 1 = data won the most recent grant; on a tie the other requester goes next.
  logic last_d_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d_q <= 1'b1;
    end else if (if_gnt) begin
      last_d_q <= 1'b0;
    end else if (d_gnt) begin
      last_d_q <= 1'b1;
    end
  end

  assign d_wins = d_req && (!if_req || !last_d_q);
`else
  assign d_wins = d_req;
`endif

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = 4'b0000;
    if (reset) begin
      if (ld_wen) begin
        ram_wen   = 1'b1;
        ram_addr  = ld_addr;
        ram_wdata = ld_wdata;
        ram_wstrb = 4'b1111;
      end else if (d_wins) begin
        d_gnt     = 1'b1;
        ram_wen   = d_wen;
        ram_addr  = d_addr;
        ram_wdata = d_wen ? d_wdata : '0;
        ram_wstrb = d_wen ? d_wstrb : 4'b0000;
      end else if (if_req) begin
        if_gnt   = 1'b1;
        ram_addr = if_addr;
      end
    end
  end

  // Only reads enter the tag pipe; stores and loader writes complete at the grant edge.
  assign rd_gnt = if_gnt || (d_gnt && !d_wen);
  assign rd_own = d_gnt ? OWN_D : OWN_IF;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_gnt;
      tag_own_q[0] <= rd_own;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  // Gating with reset keeps a response landing in a reset cycle from escaping.
  assign rsp_vld   = tag_vld_q[RD_LAT-1] && reset;
  assign rsp_own   = tag_own_q[RD_LAT-1];
  assign if_rvalid = rsp_vld && (rsp_own == OWN_IF);
  assign d_rvalid  = rsp_vld && (rsp_own == OWN_D);
  assign if_rdata  = if_rvalid ? ram_rdata : '0;
  assign d_rdata   = d_rvalid ? ram_rdata : '0;

  assign stall_evt = (if_req && !if_gnt) || (d_req && !d_gnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_if_q    <= '0;
      cnt_d_q     <= '0;
      cnt_stall_q <= '0;
    end else begin
      cnt_if_q    <= cnt_if_q + {31'b0, if_gnt};
      cnt_d_q     <= cnt_d_q + {31'b0, d_gnt};
      cnt_stall_q <= cnt_stall_q + {31'b0, stall_evt};
    end
  end

  assign cnt_if_gnt = cnt_if_q;
  assign cnt_d_gnt  = cnt_d_q;
  assign cnt_stall  = cnt_stall_q;

endmodule
